// File: rtl/core_c1_sb_pkg.sv
// Shared definitions for the core_c1 system-bus arbiter.
// Holds width defaults, path FSM state encoding and owner encoding.
package core_c1_sb_pkg;

    localparam int SB_AW = 32;
    localparam int SB_DW = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/core_c1_sb_arb_if.sv
// One sb link (read ar/r + write w/b); master drives requests, slave responses.
// Ports: ar/r and w/b channel signals, see modports below.
interface core_c1_sb_arb_if
    import core_c1_sb_pkg::*;
#(
    parameter int AW = SB_AW,
    parameter int DW = SB_DW
);
    logic            sb_arvalid;
    logic            sb_arready;
    logic [AW-1:0]   sb_araddr;
    logic            sb_rvalid;
    logic            sb_rready;
    logic [DW-1:0]   sb_rdata;
    logic            sb_wvalid;
    logic            sb_wready;
    logic [AW-1:0]   sb_waddr;
    logic [DW-1:0]   sb_wdata;
    logic [DW/8-1:0] sb_wstrb;
    logic            sb_bvalid;
    logic            sb_bready;
    logic            sb_bresp;

    modport master (
        output sb_arvalid, sb_araddr, sb_rready,
        output sb_wvalid, sb_waddr, sb_wdata, sb_wstrb, sb_bready,
        input  sb_arready, sb_rvalid, sb_rdata,
        input  sb_wready, sb_bvalid, sb_bresp
    );

    modport slave (
        input  sb_arvalid, sb_araddr, sb_rready,
        input  sb_wvalid, sb_waddr, sb_wdata, sb_wstrb, sb_bready,
        output sb_arready, sb_rvalid, sb_rdata,
        output sb_wready, sb_bvalid, sb_bresp
    );

endinterface

// File: rtl/core_c1_sb_arb_path.sv
// One arbitrated path (request + response), one outstanding transaction.
// Ports: req_* from two masters, s_* to slave, rsp_* response routing, owner.
// Optional macro SB_ARB_RR_EN: round-robin pointer instead of m1 priority.
module core_c1_sb_arb_path
    import core_c1_sb_pkg::*;
#(
    parameter int PW = SB_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    input  logic [PW-1:0] req_pay0,
    input  logic [PW-1:0] req_pay1,
    output logic [1:0]    req_ready,
    output logic          s_valid,
    output logic [PW-1:0] s_pay,
    input  logic          s_ready,
    input  logic          rsp_valid_s,
    output logic          rsp_ready_s,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic [1:0]    rsp_sel,
    output logic          owner
);

    arb_state_t state, state_n;
    logic owner_n;
    logic locked, locked_n;
    logic lock_own, lock_own_n;
    logic grant, prio;
    logic addr_hs, rsp_hs;

`ifdef SB_ARB_RR_EN
    logic ptr;

    // Favour the master that lost the last address handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= OWN_M1;
        else if (addr_hs)
            ptr <= ~grant;
    end

    assign prio = ptr;
`else
    assign prio = OWN_M1;
`endif

    // A presented-but-stalled request keeps its grant until it completes
    // or its master withdraws valid.
    always_comb begin
        grant = OWN_M0;
        if (locked)
            grant = lock_own;
        else if (&req_valid)
            grant = prio;
        else if (req_valid[1])
            grant = OWN_M1;
    end

    assign addr_hs = s_valid & s_ready;
    assign rsp_hs  = rsp_valid_s & rsp_ready_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            owner    <= OWN_M0;
            locked   <= 1'b0;
            lock_own <= OWN_M0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            locked   <= locked_n;
            lock_own <= lock_own_n;
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        locked_n   = 1'b0;
        lock_own_n = lock_own;
        unique case (state)
            ARB_IDLE: begin
                locked_n   = s_valid & ~s_ready;
                lock_own_n = grant;
                if (addr_hs) begin
                    state_n = ARB_WAIT;
                    owner_n = grant;
                end
            end
            ARB_WAIT: begin
                if (rsp_hs)
                    state_n = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        s_valid     = 1'b0;
        s_pay       = '0;
        req_ready   = 2'b00;
        rsp_sel     = 2'b00;
        rsp_ready_s = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                s_valid = req_valid[grant];
                if (s_valid)
                    s_pay = grant ? req_pay1 : req_pay0;
                req_ready[grant] = s_ready & req_valid[grant];
                // Stray responses are drained, never forwarded.
                rsp_ready_s = rsp_valid_s;
            end
            ARB_WAIT: begin
                rsp_sel[owner] = 1'b1;
                rsp_ready_s    = rsp_ready[owner];
            end
        endcase
    end

    assign rsp_valid = rsp_sel & {2{rsp_valid_s}};

endmodule

// File: rtl/core_c1_sb_arb.sv
// Two-master to one-slave sb arbiter; read and write paths arbitrated apart.
// Ports: clk, rst, m0/m1 (slave modports), s (master modport), rd/wr_owner.
// Optional macro SB_ARB_RR_EN selects round-robin arbitration.
module core_c1_sb_arb
    import core_c1_sb_pkg::*;
#(
    parameter int AW = SB_AW,
    parameter int DW = SB_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    core_c1_sb_arb_if.slave        m0,
    core_c1_sb_arb_if.slave        m1,
    core_c1_sb_arb_if.master       s,
    output logic                   rd_owner,
    output logic                   wr_owner
);

    localparam int WPW = AW + DW + DW / 8;

    logic [1:0]     ar_ready, r_valid, r_sel;
    logic [1:0]     w_ready, b_valid, b_sel;
    logic [WPW-1:0] w_pay;

    core_c1_sb_arb_path #(.PW(AW)) u_rd (
        .clk         (clk),
        .rst         (rst),
        .req_valid   ({m1.sb_arvalid, m0.sb_arvalid}),
        .req_pay0    (m0.sb_araddr),
        .req_pay1    (m1.sb_araddr),
        .req_ready   (ar_ready),
        .s_valid     (s.sb_arvalid),
        .s_pay       (s.sb_araddr),
        .s_ready     (s.sb_arready),
        .rsp_valid_s (s.sb_rvalid),
        .rsp_ready_s (s.sb_rready),
        .rsp_valid   (r_valid),
        .rsp_ready   ({m1.sb_rready, m0.sb_rready}),
        .rsp_sel     (r_sel),
        .owner       (rd_owner)
    );

    core_c1_sb_arb_path #(.PW(WPW)) u_wr (
        .clk         (clk),
        .rst         (rst),
        .req_valid   ({m1.sb_wvalid, m0.sb_wvalid}),
        .req_pay0    ({m0.sb_waddr, m0.sb_wdata, m0.sb_wstrb}),
        .req_pay1    ({m1.sb_waddr, m1.sb_wdata, m1.sb_wstrb}),
        .req_ready   (w_ready),
        .s_valid     (s.sb_wvalid),
        .s_pay       (w_pay),
        .s_ready     (s.sb_wready),
        .rsp_valid_s (s.sb_bvalid),
        .rsp_ready_s (s.sb_bready),
        .rsp_valid   (b_valid),
        .rsp_ready   ({m1.sb_bready, m0.sb_bready}),
        .rsp_sel     (b_sel),
        .owner       (wr_owner)
    );

    assign {s.sb_waddr, s.sb_wdata, s.sb_wstrb} = w_pay;

    assign m0.sb_arready = ar_ready[0];
    assign m1.sb_arready = ar_ready[1];
    assign m0.sb_rvalid  = r_valid[0];
    assign m1.sb_rvalid  = r_valid[1];
    assign m0.sb_rdata   = r_sel[0] ? s.sb_rdata : '0;
    assign m1.sb_rdata   = r_sel[1] ? s.sb_rdata : '0;

    assign m0.sb_wready  = w_ready[0];
    assign m1.sb_wready  = w_ready[1];
    assign m0.sb_bvalid  = b_valid[0];
    assign m1.sb_bvalid  = b_valid[1];
    assign m0.sb_bresp   = b_sel[0] & s.sb_bresp;
    assign m1.sb_bresp   = b_sel[1] & s.sb_bresp;

endmodule

// File: tb/tb_core_c1_sb_arb.sv
// Directed bench for core_c1_sb_arb with response scoreboards.
// Drives two masters and a slave from one linear initial block.
module tb_core_c1_sb_arb;

    logic clk;
    logic rst;
    logic rd_owner;
    logic wr_owner;

    core_c1_sb_arb_if #(.AW(32), .DW(32)) m0_if ();
    core_c1_sb_arb_if #(.AW(32), .DW(32)) m1_if ();
    core_c1_sb_arb_if #(.AW(32), .DW(32)) s_if ();

    core_c1_sb_arb #(.AW(32), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .rd_owner (rd_owner),
        .wr_owner (wr_owner)
    );

    typedef struct packed {
        logic        who;
        logic [31:0] data;
    } exp_t;

    exp_t rq[$];
    exp_t wq[$];
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the pending grant, records the expected read data, completes ar.
    task automatic ar_grant(input logic who, input logic [31:0] addr,
                            input logic [31:0] data);
        exp_t e;
        #1;
        chk("ar_s_valid", s_if.sb_arvalid, 1);
        chk("ar_s_addr", s_if.sb_araddr, addr);
        chk("ar_ready_m0", m0_if.sb_arready, who == 1'b0);
        chk("ar_ready_m1", m1_if.sb_arready, who == 1'b1);
        e.who  = who;
        e.data = data;
        rq.push_back(e);
        step();
        if (who) m1_if.sb_arvalid = 1'b0;
        else     m0_if.sb_arvalid = 1'b0;
        chk("rd_owner", rd_owner, who);
        chk("ar_blocked", s_if.sb_arvalid, 0);
    endtask

    task automatic read_rsp(input logic [31:0] data);
        exp_t e;
        logic who;
        s_if.sb_rvalid = 1'b1;
        s_if.sb_rdata  = data;
        #1;
        chk("r_valid_any", m0_if.sb_rvalid | m1_if.sb_rvalid, 1);
        who = m1_if.sb_rvalid;
        if (rq.size() == 0) begin
            chk("r_sb_nonempty", 0, 1);
        end else begin
            e = rq.pop_front();
            chk("r_owner", who, e.who);
            chk("r_data", who ? m1_if.sb_rdata : m0_if.sb_rdata, e.data);
            chk("r_other_valid",
                who ? m0_if.sb_rvalid : m1_if.sb_rvalid, 0);
            chk("r_other_data",
                who ? m0_if.sb_rdata : m1_if.sb_rdata, 0);
        end
        step();
        s_if.sb_rvalid = 1'b0;
    endtask

    task automatic b_rsp(input logic resp);
        exp_t e;
        logic who;
        s_if.sb_bvalid = 1'b1;
        s_if.sb_bresp  = resp;
        #1;
        chk("b_valid_any", m0_if.sb_bvalid | m1_if.sb_bvalid, 1);
        who = m1_if.sb_bvalid;
        if (wq.size() == 0) begin
            chk("b_sb_nonempty", 0, 1);
        end else begin
            e = wq.pop_front();
            chk("b_owner", who, e.who);
            chk("b_resp", who ? m1_if.sb_bresp : m0_if.sb_bresp, e.data);
            chk("b_other_valid",
                who ? m0_if.sb_bvalid : m1_if.sb_bvalid, 0);
        end
        step();
        // Slave keeps bvalid one extra cycle: must be drained, not forwarded.
        chk("b_one_cycle", m0_if.sb_bvalid | m1_if.sb_bvalid, 0);
        chk("b_drain", s_if.sb_bready, 1);
        s_if.sb_bvalid = 1'b0;
        s_if.sb_bresp  = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        m0_if.sb_arvalid = 0; m0_if.sb_araddr = 0; m0_if.sb_rready = 1;
        m0_if.sb_wvalid = 0; m0_if.sb_waddr = 0; m0_if.sb_wdata = 0;
        m0_if.sb_wstrb = 0; m0_if.sb_bready = 1;
        m1_if.sb_arvalid = 0; m1_if.sb_araddr = 0; m1_if.sb_rready = 1;
        m1_if.sb_wvalid = 0; m1_if.sb_waddr = 0; m1_if.sb_wdata = 0;
        m1_if.sb_wstrb = 0; m1_if.sb_bready = 1;
        s_if.sb_arready = 0; s_if.sb_rvalid = 0; s_if.sb_rdata = 0;
        s_if.sb_wready = 0; s_if.sb_bvalid = 0; s_if.sb_bresp = 0;

        // Reset state
        step();
        chk("rst_arvalid_s", s_if.sb_arvalid, 0);
        chk("rst_wvalid_s", s_if.sb_wvalid, 0);
        chk("rst_rready_s", s_if.sb_rready, 0);
        chk("rst_rvalid_m0", m0_if.sb_rvalid, 0);
        chk("rst_bvalid_m1", m1_if.sb_bvalid, 0);
        chk("rst_rd_owner", rd_owner, 0);
        chk("rst_wr_owner", wr_owner, 0);
        rst = 1'b0;
        step();
        chk("post_rst_arready_m0", m0_if.sb_arready, 0);
        chk("post_rst_rdata_m0", m0_if.sb_rdata, 0);
        chk("post_rst_araddr_s", s_if.sb_araddr, 0);

        // Single m0 read, data three cycles after ar
        s_if.sb_arready  = 1'b1;
        m0_if.sb_arvalid = 1'b1;
        m0_if.sb_araddr  = 32'h0000_0100;
        ar_grant(1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        step();
        step();
        chk("wait_rvalid_m1", m1_if.sb_rvalid, 0);
        read_rsp(32'hDEAD_BEEF);

        // Contention; m1 re-requests straight away
        m0_if.sb_arvalid = 1'b1;
        m0_if.sb_araddr  = 32'h0000_0100;
        m1_if.sb_arvalid = 1'b1;
        m1_if.sb_araddr  = 32'h0000_0200;
        ar_grant(1'b1, 32'h0000_0200, 32'hAAAA_0200);
        m1_if.sb_arvalid = 1'b1;
        m1_if.sb_araddr  = 32'h0000_0204;
        #1;
        chk("wait_no_arready_m0", m0_if.sb_arready, 0);
        chk("wait_no_arready_m1", m1_if.sb_arready, 0);
        read_rsp(32'hAAAA_0200);
`ifdef SB_ARB_RR_EN
        ar_grant(1'b0, 32'h0000_0100, 32'hAAAA_0100);
        read_rsp(32'hAAAA_0100);
        ar_grant(1'b1, 32'h0000_0204, 32'hAAAA_0204);
        read_rsp(32'hAAAA_0204);
`else
        ar_grant(1'b1, 32'h0000_0204, 32'hAAAA_0204);
        read_rsp(32'hAAAA_0204);
        ar_grant(1'b0, 32'h0000_0100, 32'hAAAA_0100);
        read_rsp(32'hAAAA_0100);
`endif

        // Slave stalls arready for 4 cycles; m1 rises mid-stall
        s_if.sb_arready  = 1'b0;
        m0_if.sb_arvalid = 1'b1;
        m0_if.sb_araddr  = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_araddr_s", s_if.sb_araddr, 32'h0000_0100);
            chk("stall_arready_m0", m0_if.sb_arready, 0);
            chk("stall_arready_m1", m1_if.sb_arready, 0);
            step();
            if (i == 1) begin
                m1_if.sb_arvalid = 1'b1;
                m1_if.sb_araddr  = 32'h0000_0200;
            end
        end
        s_if.sb_arready = 1'b1;
        ar_grant(1'b0, 32'h0000_0100, 32'h5555_0100);
        read_rsp(32'h5555_0100);
        ar_grant(1'b1, 32'h0000_0200, 32'h5555_0200);
        read_rsp(32'h5555_0200);

        // Concurrent m0 read and m1 write
        s_if.sb_wready   = 1'b1;
        m0_if.sb_arvalid = 1'b1;
        m0_if.sb_araddr  = 32'h0000_0300;
        m1_if.sb_wvalid  = 1'b1;
        m1_if.sb_waddr   = 32'h2000_0000;
        m1_if.sb_wdata   = 32'h1234_5678;
        m1_if.sb_wstrb   = 4'hF;
        #1;
        chk("cc_arvalid_s", s_if.sb_arvalid, 1);
        chk("cc_wvalid_s", s_if.sb_wvalid, 1);
        chk("cc_waddr_s", s_if.sb_waddr, 32'h2000_0000);
        chk("cc_wdata_s", s_if.sb_wdata, 32'h1234_5678);
        chk("cc_wstrb_s", s_if.sb_wstrb, 4'hF);
        chk("cc_wready_m1", m1_if.sb_wready, 1);
        chk("cc_wready_m0", m0_if.sb_wready, 0);
        chk("cc_arready_m0", m0_if.sb_arready, 1);
        e.who = 1'b0; e.data = 32'hC0DE_0300; rq.push_back(e);
        e.who = 1'b1; e.data = 32'h0;         wq.push_back(e);
        step();
        m0_if.sb_arvalid = 1'b0;
        m1_if.sb_wvalid  = 1'b0;
        chk("cc_rd_owner", rd_owner, 0);
        chk("cc_wr_owner", wr_owner, 1);
        read_rsp(32'hC0DE_0300);
        b_rsp(1'b0);

        // Error response to m1
        m1_if.sb_wvalid = 1'b1;
        m1_if.sb_waddr  = 32'h2000_0004;
        m1_if.sb_wdata  = 32'hCAFE_F00D;
        m1_if.sb_wstrb  = 4'h3;
        #1;
        chk("err_wready_m1", m1_if.sb_wready, 1);
        chk("err_wstrb_s", s_if.sb_wstrb, 4'h3);
        e.who = 1'b1; e.data = 32'h1; wq.push_back(e);
        step();
        m1_if.sb_wvalid = 1'b0;
        b_rsp(1'b1);

        // Reset while the read path waits for data
        m0_if.sb_arvalid = 1'b1;
        m0_if.sb_araddr  = 32'h0000_0400;
        ar_grant(1'b0, 32'h0000_0400, 32'h0);
        rst = 1'b1;
        #1;
        rq.delete();
        chk("mid_rst_arvalid_s", s_if.sb_arvalid, 0);
        chk("mid_rst_arready_m0", m0_if.sb_arready, 0);
        chk("mid_rst_rvalid_m0", m0_if.sb_rvalid, 0);
        chk("mid_rst_rd_owner", rd_owner, 0);
        step();
        rst = 1'b0;
        step();
        s_if.sb_rvalid = 1'b1;
        s_if.sb_rdata  = 32'hBAD0_BAD0;
        #1;
        chk("late_rvalid_m0", m0_if.sb_rvalid, 0);
        chk("late_rvalid_m1", m1_if.sb_rvalid, 0);
        chk("late_rdata_m0", m0_if.sb_rdata, 0);
        chk("late_drain", s_if.sb_rready, 1);
        step();
        s_if.sb_rvalid = 1'b0;

        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
